arbitro_escrita_banco: RTL and testbench

ARBITRO_ESCRITA_BANCO -- requirements
Module: arbitro_escrita_banco

---
 rtl/arbitro_escrita_banco.sv | 153 +++++++++++++++
 tb/tb_arbitro_escrita_banco.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_escrita_banco.sv
// arbitro_escrita_banco
//   Merges two register-file writeback streams (A = ALU, B = load) onto the
//   single register-file write port. Each requester owns one holding slot; the
//   older held entry is granted first, and same-edge ties alternate through a
//   round-robin pointer. The write port outputs are registered.
//
// Ports
//   clock, reset_n        : rising-edge clock, synchronous active-low reset
//   a_valid/a_ready       : requester A handshake (accept when both high)
//   a_reg, a_data         : requester A destination register and value
//   b_*                   : same as A, for requester B
//   RegWrite              : registered write enable to the register file
//   WriteReg, WriteData   : registered write address / data
//   pending               : bit r high while a write to r is held or issued
module arbitro_escrita_banco #(
  parameter int SIZE = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_reg,
  input  logic [SIZE-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_reg,
  input  logic [SIZE-1:0] b_data,
  output logic            RegWrite,
  output logic [4:0]      WriteReg,
  output logic [SIZE-1:0] WriteData,
  output logic [31:0]     pending
);

  // Relative age of the two held entries; only meaningful when both are full.
  typedef enum logic [1:0] {
    ORD_TIE     = 2'd0,
    ORD_A_OLDER = 2'd1,
    ORD_B_OLDER = 2'd2
  } ord_t;

  logic            a_full_q, a_full_d;
  logic            b_full_q, b_full_d;
  logic [4:0]      a_reg_q, a_reg_d;
  logic [4:0]      b_reg_q, b_reg_d;
  logic [SIZE-1:0] a_data_q, a_data_d;
  logic [SIZE-1:0] b_data_q, b_data_d;
  ord_t            ord_q, ord_d;
  logic            rr_q, rr_d;          // 0 = A wins next tie, 1 = B
  logic            reg_write_q, reg_write_d;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [SIZE-1:0] write_data_q, write_data_d;

  logic grant_a, grant_b, tie_break;
  logic load_a, load_b;

  // Grant selection from the held slots.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    tie_break = 1'b0;
    if (a_full_q && b_full_q) begin
      case (ord_q)
        ORD_A_OLDER: grant_a = 1'b1;
        ORD_B_OLDER: grant_b = 1'b1;
        default: begin
          tie_break = 1'b1;
          if (rr_q) grant_b = 1'b1;
          else      grant_a = 1'b1;
        end
      endcase
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  // Ready is forced high during reset; the reset branch below discards the accept.
  assign a_ready = !reset_n || !a_full_q || grant_a;
  assign b_ready = !reset_n || !b_full_q || grant_b;

  // Writes to $zero complete the handshake but never occupy a slot.
  assign load_a = a_valid && a_ready && (a_reg != 5'd0);
  assign load_b = b_valid && b_ready && (b_reg != 5'd0);

  always_comb begin
    a_full_d     = load_a || (a_full_q && !grant_a);
    b_full_d     = load_b || (b_full_q && !grant_b);
    a_reg_d      = load_a ? a_reg  : a_reg_q;
    a_data_d     = load_a ? a_data : a_data_q;
    b_reg_d      = load_b ? b_reg  : b_reg_q;
    b_data_d     = load_b ? b_data : b_data_q;
    rr_d         = rr_q ^ tie_break;

    // A freshly loaded entry is always younger than the one in the other slot.
    ord_d = ord_q;
    if (load_a && load_b) ord_d = ORD_TIE;
    else if (load_a)      ord_d = ORD_B_OLDER;
    else if (load_b)      ord_d = ORD_A_OLDER;

    reg_write_d  = grant_a || grant_b;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant_a) begin
      write_reg_d  = a_reg_q;
      write_data_d = a_data_q;
    end else if (grant_b) begin
      write_reg_d  = b_reg_q;
      write_data_d = b_data_q;
    end
  end

  // Held slots plus the write currently on the port all count as outstanding.
  always_comb begin
    pending = 32'd0;
    if (a_full_q)    pending[a_reg_q]     = 1'b1;
    if (b_full_q)    pending[b_reg_q]     = 1'b1;
    if (reg_write_q) pending[write_reg_q] = 1'b1;
    pending[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_full_q     <= 1'b0;
      b_full_q     <= 1'b0;
      ord_q        <= ORD_TIE;
      rr_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
    end else begin
      a_full_q     <= a_full_d;
      b_full_q     <= b_full_d;
      ord_q        <= ord_d;
      rr_q         <= rr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Slot payloads are qualified by the full flags and need no reset.
  always_ff @(posedge clock) begin
    a_reg_q  <= a_reg_d;
    a_data_q <= a_data_d;
    b_reg_q  <= b_reg_d;
    b_data_q <= b_data_d;
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
module tb_arbitro_escrita_banco;

  localparam int SIZE = 32;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [4:0]      a_reg, b_reg;
  logic [SIZE-1:0] a_data, b_data;
  logic            RegWrite;
  logic [4:0]      WriteReg;
  logic [SIZE-1:0] WriteData;
  logic [31:0]     pending;

  arbitro_escrita_banco #(.SIZE(SIZE)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .pending(pending)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot remembers the cycle number of its accept; smaller number = older.
  bit              m_full [2];
  logic [4:0]      m_reg  [2];
  logic [SIZE-1:0] m_data [2];
  int              m_stamp[2];
  bit              m_rr;
  bit              m_rw;
  logic [4:0]      m_wreg;
  logic [SIZE-1:0] m_wdata;
  int              m_cnt  [32];   // outstanding writes per register
  logic [SIZE-1:0] m_rf   [32];
  int              cyc_no = 0;

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_stamp[0] < m_stamp[1]) return 0;
      if (m_stamp[1] < m_stamp[0]) return 1;
      return m_rr ? 1 : 0;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(input int x);
    return !reset_n || !m_full[x] || (m_grant() == x);
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] > 0);
    return p;
  endfunction

  task automatic model_step();
    int  g;
    bit  ra, rb, tie;
    g   = m_grant();
    ra  = m_ready(0);
    rb  = m_ready(1);
    tie = m_full[0] && m_full[1] && (m_stamp[0] == m_stamp[1]);
    if (!reset_n) begin
      m_full[0] = 0; m_full[1] = 0; m_rr = 0; m_rw = 0;
      m_wreg = '0; m_wdata = '0;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      if (m_rw) begin
        m_rf[m_wreg] = m_wdata;
        m_cnt[m_wreg]--;
      end
      if (g >= 0) begin
        m_rw = 1; m_wreg = m_reg[g]; m_wdata = m_data[g]; m_full[g] = 0;
        if (tie) m_rr = !m_rr;
      end else begin
        m_rw = 0;
      end
      if (a_valid && ra && a_reg != 0) begin
        m_full[0] = 1; m_reg[0] = a_reg; m_data[0] = a_data; m_stamp[0] = cyc_no;
        m_cnt[a_reg]++;
      end
      if (b_valid && rb && b_reg != 0) begin
        m_full[1] = 1; m_reg[1] = b_reg; m_data[1] = b_data; m_stamp[1] = cyc_no;
        m_cnt[b_reg]++;
      end
    end
    cyc_no++;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("a_ready",   a_ready,   m_ready(0));
      check("b_ready",   b_ready,   m_ready(1));
      check("RegWrite",  RegWrite,  m_rw);
      check("WriteReg",  WriteReg,  m_wreg);
      check("WriteData", WriteData, m_wdata);
      check("pending",   pending,   m_pending());
    end
  end

  // Register file seen by the DUT's write port, plus an issue log.
  logic [SIZE-1:0] rf_dut [32];
  logic [SIZE-1:0] log_data [256];
  int              log_n = 0;
  always @(posedge clock) begin
    if (reset_n && RegWrite) begin
      rf_dut[WriteReg]  <= WriteData;
      log_data[log_n]   <= WriteData;
      log_n             <= log_n + 1;
    end
  end

  // Advance one clock: model takes the edge with the inputs now applied.
  task automatic cyc();
    @(negedge clock);
    #1;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0;
  endtask

  int base;
  int rw_count;

  initial begin
    reset_n = 0; a_valid = 0; b_valid = 0;
    a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; m_cnt[r] = 0; end
    m_full[0] = 0; m_full[1] = 0; m_rr = 0; m_rw = 0; m_wreg = 0; m_wdata = 0;

    // Reset
    cyc();
    chk_en = 1;
    cyc();
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_pending",  pending,  32'd0);
    check("rst_a_ready",  a_ready,  1'b1);
    reset_n = 1;
    cyc();

    // A only: reg 5 = 0x1234
    a_valid = 1; a_reg = 5; a_data = 32'h1234;
    cyc();                                   // edge 1
    idle();
    check("a_only_pend5_e1", pending[5], 1'b1);
    check("a_only_rw_e1",    RegWrite,   1'b0);
    cyc();                                   // edge 2
    check("a_only_rw_e2",    RegWrite,   1'b1);
    check("a_only_wreg_e2",  WriteReg,   5'd5);
    check("a_only_wdata_e2", WriteData,  32'h1234);
    check("a_only_pend5_e2", pending[5], 1'b1);
    cyc();                                   // edge 3
    check("a_only_pend5_e3", pending[5], 1'b0);
    check("a_only_rw_e3",    RegWrite,   1'b0);

    // Tie: A first, then repeat with B first
    for (int rep = 0; rep < 2; rep++) begin
      a_valid = 1; a_reg = 3; a_data = 32'hA;
      b_valid = 1; b_reg = 4; b_data = 32'hB;
      cyc();
      idle();
      cyc();
      check("tie_first",  WriteReg, (rep == 0) ? 5'd3 : 5'd4);
      cyc();
      check("tie_second", WriteReg, (rep == 0) ? 5'd4 : 5'd3);
      cyc();
    end

    // Ordering on reg 7: B(0x1), then A(0x2) one edge later
    b_valid = 1; b_reg = 7; b_data = 32'h1;
    cyc();
    idle();
    a_valid = 1; a_reg = 7; a_data = 32'h2;
    cyc();
    idle();
    for (int i = 0; i < 4; i++) cyc();
    check("order_rf7", rf_dut[7], 32'h2);

    // Contested ordering: tie (A wins by pointer), A refilled with reg 7
    // while B's older reg-7 entry waits -> B must issue before new A.
    base = log_n;
    a_valid = 1; a_reg = 9; a_data = 32'h9;
    b_valid = 1; b_reg = 7; b_data = 32'h1;
    cyc();
    b_valid = 0;
    a_valid = 1; a_reg = 7; a_data = 32'h2;
    cyc();
    idle();
    for (int i = 0; i < 5; i++) cyc();
    check("aged_log0", log_data[base],     32'h9);
    check("aged_log1", log_data[base + 1], 32'h1);
    check("aged_log2", log_data[base + 2], 32'h2);
    check("aged_rf7",  rf_dut[7],          32'h2);
    check("aged_cnt",  log_n - base,       3);

    // $zero write
    a_valid = 1; a_reg = 0; a_data = 32'hDEAD;
    check("zero_ready", a_ready, 1'b1);
    cyc();
    idle();
    check("zero_pend", pending, 32'd0);
    cyc();
    check("zero_rw", RegWrite, 1'b0);
    cyc();

    // Back-to-back: 8 writes from A
    rw_count = 0;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_reg = 5'(i + 1); a_data = 32'(i * 3 + 1);
      check("b2b_ready", a_ready, 1'b1);
      cyc();
      if (RegWrite) rw_count++;
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (RegWrite) rw_count++;
    end
    check("b2b_count", rw_count, 8);

    // Reset mid-operation with both slots full
    a_valid = 1; a_reg = 10; a_data = 32'h10;
    b_valid = 1; b_reg = 11; b_data = 32'h11;
    cyc();
    idle();
    reset_n = 0;
    cyc();
    reset_n = 1;
    check("midrst_rw",   RegWrite, 1'b0);
    check("midrst_pend", pending,  32'd0);
    rw_count = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (RegWrite) rw_count++;
    end
    check("midrst_nowrite", rw_count, 0);

    // Deterministic mixed traffic, including $zero and shared registers
    for (int i = 0; i < 24; i++) begin
      a_valid = (i % 3) != 2; a_reg = 5'((i * 7) % 8); a_data = 32'(i + 100);
      b_valid = (i % 4) != 0; b_reg = 5'((i * 5) % 8); b_data = 32'(i + 200);
      cyc();
    end
    idle();
    for (int i = 0; i < 5; i++) cyc();
    for (int r = 1; r < 8; r++) check("mix_rf", rf_dut[r], m_rf[r]);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
